// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared raster timing constants and helpers for vga_timing_gen.
// Contents:
//   - Default 800x600@72Hz horizontal/vertical timing (pixels / lines).
//   - Derived line and frame totals.
//   - phase_e: 2-bit raster phase shared by the horizontal and vertical FSMs.
//   - phase_of(): maps a count onto its phase for a given timing.
package vga_timing_pkg;

  localparam int unsigned DefHActive = 800;
  localparam int unsigned DefHFp     = 56;
  localparam int unsigned DefHSync   = 120;
  localparam int unsigned DefHBp     = 64;

  localparam int unsigned DefVActive = 600;
  localparam int unsigned DefVFp     = 37;
  localparam int unsigned DefVSync   = 6;
  localparam int unsigned DefVBp     = 23;

  localparam int unsigned DefHTotal = DefHActive + DefHFp + DefHSync + DefHBp;  // 1040
  localparam int unsigned DefVTotal = DefVActive + DefVFp + DefVSync + DefVBp;  // 666

  // Count registers are fixed at 12 bits, so totals may not exceed this.
  localparam int unsigned MaxTotal = 4096;

  typedef enum logic [1:0] {
    PhAct   = 2'd0,
    PhFront = 2'd1,
    PhSync  = 2'd2,
    PhBack  = 2'd3
  } phase_e;

  function automatic int unsigned span_total(input int unsigned act, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

  function automatic phase_e phase_of(input logic [11:0] pos, input int unsigned act,
                                      input int unsigned fp, input int unsigned sync);
    int unsigned p;
    p = 32'(pos);
    if (p < act) begin
      return PhAct;
    end else if (p < act + fp) begin
      return PhFront;
    end else if (p < act + fp + sync) begin
      return PhSync;
    end else begin
      return PhBack;
    end
  endfunction

endpackage

// File: rtl/clk_enable_div.sv
// clk_enable_div: divides the fabric clock into a one-cycle enable strobe.
// Ports:
//   clk     in   fabric clock
//   reset   in   asynchronous active-high reset
//   en      out  registered strobe, high for one clk every DIV clks
//   en_next out  combinational value en takes at the next edge; lets a consumer update
//                state on the same edge en rises, so its outputs line up with en
// The first en arrives DIV clks after reset release. DIV=1 gives en high every clk.
module clk_enable_div #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic reset,
  output logic en,
  output logic en_next
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    en_next = (cnt_q == CntW'(DIV - 1));
    cnt_d   = en_next ? '0 : cnt_q + CntW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      en    <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      en    <= en_next;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator, 800x600@72Hz by default, running on the fabric
// clock with a pixel enable.
// Ports:
//   clk         in   fabric clock
//   reset       in   asynchronous active-high reset
//   decr_en     in   enables decr_tick generation
//   pix_en      out  one-clk strobe every CLK_DIV clks; counters advance with it
//   x_p         out  horizontal count 0..H_TOTAL-1
//   y_p         out  vertical count 0..V_TOTAL-1
//   video_on    out  high inside the visible area
//   hsync       out  SYNC_POL during the horizontal sync interval
//   vsync       out  SYNC_POL during the vertical sync interval
//   frame_start out  one-clk pulse in the clk x_p,y_p become (0,0)
//   decr_tick   out  one-clk pulse with frame_start every DECR_FRAMES frames
// All outputs are registered. Phase, sync and video outputs are computed from the next
// count and registered on the same edge as the count, so they never skew from x_p/y_p.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 2,
  parameter int unsigned H_ACTIVE    = DefHActive,
  parameter int unsigned H_FP        = DefHFp,
  parameter int unsigned H_SYNC      = DefHSync,
  parameter int unsigned H_BP        = DefHBp,
  parameter int unsigned V_ACTIVE    = DefVActive,
  parameter int unsigned V_FP        = DefVFp,
  parameter int unsigned V_SYNC      = DefVSync,
  parameter int unsigned V_BP        = DefVBp,
  parameter bit          SYNC_POL    = 1'b1,
  parameter int unsigned DECR_FRAMES = 72
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        decr_en,
  output logic        pix_en,
  output logic [11:0] x_p,
  output logic [11:0] y_p,
  output logic        video_on,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start,
  output logic        decr_tick
);

  localparam int unsigned H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned FcW     = $clog2(DECR_FRAMES + 1);

  if (H_TOTAL > MaxTotal || V_TOTAL > MaxTotal) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 12-bit count range");
  end
  if (CLK_DIV < 1 || DECR_FRAMES < 1) begin : g_bad_param
    $error("vga_timing_gen: CLK_DIV and DECR_FRAMES must be >= 1");
  end

  logic           adv;  // pix_en rises on this edge
  logic [11:0]    x_d, y_d;
  logic           x_wrap, y_wrap, frame_wrap;
  phase_e         h_ph_q, h_ph_d, v_ph_q, v_ph_d;
  logic [FcW-1:0] fc_q, fc_d;
  logic           tick_d;

  clk_enable_div #(
    .DIV(CLK_DIV)
  ) u_div (
    .clk    (clk),
    .reset  (reset),
    .en     (pix_en),
    .en_next(adv)
  );

  always_comb begin
    x_wrap = (x_p == 12'(H_TOTAL - 1));
    y_wrap = (y_p == 12'(V_TOTAL - 1));
    x_d    = x_p;
    y_d    = y_p;
    if (adv) begin
      if (x_wrap) begin
        x_d = '0;
        y_d = y_wrap ? '0 : y_p + 12'd1;
      end else begin
        x_d = x_p + 12'd1;
      end
    end
    frame_wrap = adv && x_wrap && y_wrap;

    // V phase only moves when y_d changes, i.e. on an x wrap.
    h_ph_d = phase_of(x_d, H_ACTIVE, H_FP, H_SYNC);
    v_ph_d = phase_of(y_d, V_ACTIVE, V_FP, V_SYNC);

    // Dropping decr_en discards the partial count and suppresses any pending tick.
    fc_d   = fc_q;
    tick_d = 1'b0;
    if (!decr_en) begin
      fc_d = '0;
    end else if (frame_wrap) begin
      if (fc_q == FcW'(DECR_FRAMES - 1)) begin
        fc_d   = '0;
        tick_d = 1'b1;
      end else begin
        fc_d = fc_q + FcW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_p         <= 12'(H_TOTAL - 1);
      y_p         <= 12'(V_TOTAL - 1);
      h_ph_q      <= phase_of(12'(H_TOTAL - 1), H_ACTIVE, H_FP, H_SYNC);
      v_ph_q      <= phase_of(12'(V_TOTAL - 1), V_ACTIVE, V_FP, V_SYNC);
      video_on    <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      frame_start <= 1'b0;
      decr_tick   <= 1'b0;
      fc_q        <= '0;
    end else begin
      x_p         <= x_d;
      y_p         <= y_d;
      h_ph_q      <= h_ph_d;
      v_ph_q      <= v_ph_d;
      video_on    <= (h_ph_d == PhAct) && (v_ph_d == PhAct);
      hsync       <= (h_ph_d == PhSync) ? SYNC_POL : ~SYNC_POL;
      vsync       <= (v_ph_d == PhSync) ? SYNC_POL : ~SYNC_POL;
      frame_start <= frame_wrap;
      decr_tick   <= tick_d;
      fc_q        <= fc_d;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench for vga_timing_gen.
// Instance d_dut uses the default 800x600@72 timing for reset and line checks.
// Instance s_dut uses a reduced raster (32 x 13, DECR_FRAMES=3) so whole frames, the
// decrement schedule and a mid-frame reset fit in a short run.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic decr_en = 1'b0;

  always #5 clk = ~clk;

  logic        d_pix_en, d_video_on, d_hsync, d_vsync, d_frame_start, d_decr_tick;
  logic [11:0] d_x, d_y;
  logic        s_pix_en, s_video_on, s_hsync, s_vsync, s_frame_start, s_decr_tick;
  logic [11:0] s_x, s_y;

  vga_timing_gen d_dut (
    .clk        (clk),
    .reset      (reset),
    .decr_en    (decr_en),
    .pix_en     (d_pix_en),
    .x_p        (d_x),
    .y_p        (d_y),
    .video_on   (d_video_on),
    .hsync      (d_hsync),
    .vsync      (d_vsync),
    .frame_start(d_frame_start),
    .decr_tick  (d_decr_tick)
  );

  vga_timing_gen #(
    .CLK_DIV    (2),
    .H_ACTIVE   (16),
    .H_FP       (4),
    .H_SYNC     (8),
    .H_BP       (4),
    .V_ACTIVE   (6),
    .V_FP       (2),
    .V_SYNC     (3),
    .V_BP       (2),
    .SYNC_POL   (1'b1),
    .DECR_FRAMES(3)
  ) s_dut (
    .clk        (clk),
    .reset      (reset),
    .decr_en    (decr_en),
    .pix_en     (s_pix_en),
    .x_p        (s_x),
    .y_p        (s_y),
    .video_on   (s_video_on),
    .hsync      (s_hsync),
    .vsync      (s_vsync),
    .frame_start(s_frame_start),
    .decr_tick  (s_decr_tick)
  );

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // Advance to the next pix_en clk; frame_start must stay low in between.
  task automatic next_pix();
    int n;
    step();
    n = 1;
    while (!s_pix_en && n < 8) begin
      chk("fs_between_pix", s_frame_start, 0);
      step();
      n++;
    end
    chk("pix_en_seen", s_pix_en, 1);
  endtask

  task automatic check_reset(input string ph);
    chk({ph, "_d_pix_en"}, d_pix_en, 0);
    chk({ph, "_d_x"}, d_x, 1039);
    chk({ph, "_d_y"}, d_y, 665);
    chk({ph, "_d_video"}, d_video_on, 0);
    chk({ph, "_d_hsync"}, d_hsync, 0);
    chk({ph, "_d_vsync"}, d_vsync, 0);
    chk({ph, "_d_fs"}, d_frame_start, 0);
    chk({ph, "_d_tick"}, d_decr_tick, 0);
    chk({ph, "_s_x"}, s_x, 31);
    chk({ph, "_s_y"}, s_y, 12);
    chk({ph, "_s_video"}, s_video_on, 0);
    chk({ph, "_s_fs"}, s_frame_start, 0);
  endtask

  // Called with reset just released at a negedge.
  task automatic check_restart(input string ph);
    step();
    chk({ph, "_pix_en_c1"}, d_pix_en, 0);
    chk({ph, "_x_c1"}, d_x, 1039);
    chk({ph, "_s_x_c1"}, s_x, 31);
    step();
    chk({ph, "_pix_en_c2"}, d_pix_en, 1);
    chk({ph, "_x_c2"}, d_x, 0);
    chk({ph, "_y_c2"}, d_y, 0);
    chk({ph, "_video_c2"}, d_video_on, 1);
    chk({ph, "_fs_c2"}, d_frame_start, 1);
    chk({ph, "_hsync_c2"}, d_hsync, 0);
    chk({ph, "_vsync_c2"}, d_vsync, 0);
    chk({ph, "_s_x_c2"}, s_x, 0);
    chk({ph, "_s_y_c2"}, s_y, 0);
    chk({ph, "_s_fs_c2"}, s_frame_start, 1);
    chk({ph, "_s_tick_c2"}, s_decr_tick, 0);
  endtask

  initial begin
    int     hs_cnt;
    int     mx, my, fnum, n;
    logic   fs;
    longint last_fs;

    // Power-on reset with decr_en already high.
    decr_en = 1'b1;
    repeat (3) step();
    check_reset("por");
    reset = 1'b0;
    check_restart("start");

    // One full default line: x_p = 0 was seen above.
    hs_cnt = 0;
    for (int i = 1; i < 1040; i++) begin
      next_pix();
      chk("line_x", d_x, i);
      chk("line_y", d_y, 0);
      chk("line_video", d_video_on, (i < 800) ? 1 : 0);
      chk("line_hsync", d_hsync, (i >= 856 && i < 976) ? 1 : 0);
      hs_cnt += int'(d_hsync);
    end
    chk("hsync_len", hs_cnt, 120);
    next_pix();
    chk("line_wrap_x", d_x, 0);
    chk("line_wrap_y", d_y, 1);

    // Reduced raster: 16 frames, ticks expected on frame_starts 3, 6, 9 and 15
    // (decr_en low from mid-frame 11 to mid-frame 12 kills the tick at 12).
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_restart("rerun");
    mx = 0;
    my = 0;
    fnum = 1;
    last_fs = cyc;
    while (fnum < 16) begin
      next_pix();
      if (mx == 31) begin
        mx = 0;
        my = (my == 12) ? 0 : my + 1;
      end else begin
        mx++;
      end
      fs = (mx == 0 && my == 0);
      if (fs) begin
        fnum++;
        chk("frame_len", 32'(cyc - last_fs), 832);
        last_fs = cyc;
      end
      chk("s_x", s_x, mx);
      chk("s_y", s_y, my);
      chk("s_video", s_video_on, (mx < 16 && my < 6) ? 1 : 0);
      chk("s_hsync", s_hsync, (mx >= 20 && mx < 28) ? 1 : 0);
      chk("s_vsync", s_vsync, (my >= 8 && my < 11) ? 1 : 0);
      chk("s_fs", s_frame_start, fs);
      chk("s_tick", s_decr_tick,
          (fs && (fnum == 3 || fnum == 6 || fnum == 9 || fnum == 15)) ? 1 : 0);
      if (fnum == 11 && my == 5 && mx == 0) decr_en = 1'b0;
      if (fnum == 12 && my == 5 && mx == 0) decr_en = 1'b1;
    end

    // Mid-frame asynchronous reset at (20, 7) of the small raster.
    n = 0;
    while (!(s_x == 12'd20 && s_y == 12'd7) && n < 1000) begin
      next_pix();
      n++;
    end
    chk("reach_mid_frame", (n < 1000) ? 1 : 0, 1);
    #2 reset = 1'b1;
    #1;
    check_reset("async");
    step();
    reset = 1'b0;
    check_restart("after_async");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
